// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment scan decoder and the
// display drivers' self-check. Segment patterns are active-low, seg[0]=a.
package seven_seg_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

  localparam seg_t SEG_HEX_0 = 7'b1000000;
  localparam seg_t SEG_HEX_1 = 7'b1111001;
  localparam seg_t SEG_HEX_2 = 7'b0100100;
  localparam seg_t SEG_HEX_3 = 7'b0110000;
  localparam seg_t SEG_HEX_4 = 7'b0011001;
  localparam seg_t SEG_HEX_5 = 7'b0010010;
  localparam seg_t SEG_HEX_6 = 7'b0000010;
  localparam seg_t SEG_HEX_7 = 7'b1111000;
  localparam seg_t SEG_HEX_8 = 7'b0000000;
  localparam seg_t SEG_HEX_9 = 7'b0010000;
  localparam seg_t SEG_HEX_A = 7'b0001000;
  localparam seg_t SEG_HEX_B = 7'b0000011;
  localparam seg_t SEG_HEX_C = 7'b1000110;
  localparam seg_t SEG_HEX_D = 7'b0100001;
  localparam seg_t SEG_HEX_E = 7'b0000110;
  localparam seg_t SEG_HEX_F = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Slot index of a one-hot-low anode vector (only meaningful when exactly one bit is low).
  function automatic logic [1:0] digit_idx(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    if (!an[1]) idx = 2'd1;
    if (!an[2]) idx = 2'd2;
    if (!an[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to hex-nibble decoder. Any pattern outside
// the 16-entry hex table (blank included) yields nibble 0 with err_o set.
module seg7_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       err_o
);

  // Table lookup; defaults cover every unrecognised pattern.
  always_comb begin
    nibble_o = 4'h0;
    err_o    = 1'b0;
    case (seg_i)
      SEG_HEX_0: nibble_o = 4'h0;
      SEG_HEX_1: nibble_o = 4'h1;
      SEG_HEX_2: nibble_o = 4'h2;
      SEG_HEX_3: nibble_o = 4'h3;
      SEG_HEX_4: nibble_o = 4'h4;
      SEG_HEX_5: nibble_o = 4'h5;
      SEG_HEX_6: nibble_o = 4'h6;
      SEG_HEX_7: nibble_o = 4'h7;
      SEG_HEX_8: nibble_o = 4'h8;
      SEG_HEX_9: nibble_o = 4'h9;
      SEG_HEX_A: nibble_o = 4'hA;
      SEG_HEX_B: nibble_o = 4'hB;
      SEG_HEX_C: nibble_o = 4'hC;
      SEG_HEX_D: nibble_o = 4'hD;
      SEG_HEX_E: nibble_o = 4'hE;
      SEG_HEX_F: nibble_o = 4'hF;
      default:   err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Watches a multiplexed 4-digit active-low 7-segment bus, rebuilds the
// displayed 16-bit hex value and publishes it after STABLE_FRAMES identical
// error-free frames. Define SEG_SYNC_EN to add a two-flop input synchronizer.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        valid,
  output logic        update,
  output logic [3:0]  digit_err,
  output logic        frame_err
);

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  STABLE_REQ  = 4'(STABLE_FRAMES);
  localparam logic [23:0] TMO_LAST    = 24'(TIMEOUT_CYCLES - 1);

  seg_t       seg_s;
  logic [3:0] an_s;

`ifdef SEG_SYNC_EN
  seg_t       seg_s1_q, seg_s2_q;
  logic [3:0] an_s1_q, an_s2_q;

  // Two-flop synchronizer, idles at all-ones (every segment and anode off).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
    end
  end

  assign seg_s = seg_s2_q;
  assign an_s  = an_s2_q;
`else
  assign seg_s = seg;
  assign an_s  = an;
`endif

  // Anode classification: exactly one low is a digit, all high is idle, else illegal.
  logic one_low, idle, illegal;
  assign one_low = (an_s == 4'b1110) || (an_s == 4'b1101) ||
                   (an_s == 4'b1011) || (an_s == 4'b0111);
  assign idle    = (an_s == 4'b1111);
  assign illegal = !one_low && !idle;

  nibble_t dec_nibble;
  logic    dec_err;

  seg7_pattern_decode u_decode (
    .seg_i    (seg_s),
    .nibble_o (dec_nibble),
    .err_o    (dec_err)
  );

  scan_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  cur_an_q, cur_an_d;
  seg_t        cur_seg_q, cur_seg_d;
  logic        cap;
  logic [1:0]  cap_idx;
  logic        start;

  // Capture FSM: settle on a digit, capture once, then hold until the anode moves.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_an_d  = cur_an_q;
    cur_seg_d = cur_seg_q;
    cap       = 1'b0;
    cap_idx   = digit_idx(cur_an_q);
    start     = 1'b0;
    unique case (state_q)
      WAIT: begin
        if (one_low) start = 1'b1;
        else         cnt_d = 8'd0;
      end
      SETTLE: begin
        if (!one_low) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end else if (an_s == cur_an_q && seg_s == cur_seg_q) begin
          if (cnt_q >= SETTLE_LAST) begin
            cap     = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          start = 1'b1;
        end
      end
      HOLD: begin
        // Segment changes are ignored here; only an anode change releases the slot.
        if (an_s != cur_an_q) begin
          if (one_low) begin
            start = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 8'd0;
          end
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = 8'd0;
      end
    endcase
    // A freshly seen digit counts as the first settled cycle.
    if (start) begin
      cur_an_d  = an_s;
      cur_seg_d = seg_s;
      cnt_d     = 8'd1;
      if (SETTLE_LAST == 8'd0) begin
        cap     = 1'b1;
        cap_idx = digit_idx(an_s);
        state_d = HOLD;
      end else begin
        state_d = SETTLE;
      end
    end
  end

  logic [15:0] slot_q, slot_d;
  logic [3:0]  derr_q, derr_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] prev_q, prev_d;
  logic [3:0]  stable_q, stable_d;
  logic [23:0] tmo_q, tmo_d;
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        update_q, update_d;
  logic        frame_err_q, frame_err_d;

  // Frame assembly, stability counting, publishing and inactivity timeout.
  always_comb begin
    slot_d      = slot_q;
    derr_d      = derr_q;
    seen_d      = seen_q;
    prev_d      = prev_q;
    stable_d    = stable_q;
    tmo_d       = tmo_q;
    value_d     = value_q;
    valid_d     = valid_q;
    update_d    = 1'b0;
    frame_err_d = frame_err_q | illegal;

    if (seen_q == 4'hF) begin
      seen_d = 4'h0;
      prev_d = slot_q;
      if (|derr_q) begin
        stable_d = 4'd0;
      end else begin
        if (slot_q == prev_q) stable_d = (stable_q == 4'hF) ? stable_q : stable_q + 4'd1;
        else                  stable_d = 4'd1;
        if (stable_d >= STABLE_REQ) begin
          value_d  = slot_q;
          valid_d  = 1'b1;
          update_d = 1'b1;
        end
      end
    end

    // Capture lands after completion handling so a same-cycle capture starts the next frame.
    if (cap) begin
      slot_d[{cap_idx, 2'b00} +: 4] = dec_nibble;
      derr_d[cap_idx]               = dec_err;
      seen_d[cap_idx]               = 1'b1;
      tmo_d                         = 24'd0;
    end else if (tmo_q >= TMO_LAST) begin
      tmo_d    = 24'd0;
      valid_d  = 1'b0;
      update_d = 1'b0;
      seen_d   = 4'h0;
      stable_d = 4'd0;
    end else begin
      tmo_d = tmo_q + 24'd1;
    end
  end

  // State registers; reset discards any partially assembled frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT;
      cnt_q       <= 8'd0;
      cur_an_q    <= 4'hF;
      cur_seg_q   <= SEG_BLANK;
      slot_q      <= 16'h0000;
      derr_q      <= 4'h0;
      seen_q      <= 4'h0;
      prev_q      <= 16'h0000;
      stable_q    <= 4'd0;
      tmo_q       <= 24'd0;
      value_q     <= 16'h0000;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_an_q    <= cur_an_d;
      cur_seg_q   <= cur_seg_d;
      slot_q      <= slot_d;
      derr_q      <= derr_d;
      seen_q      <= seen_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign update    = update_q;
  assign digit_err = derr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder: table of scanned frames
// with expected outputs, an update scoreboard, and hand-written sequences
// for timeout, illegal anodes and mid-settle reset.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        valid;
  logic        update;
  logic [3:0]  digit_err;
  logic        frame_err;

  seven_seg_scan_decoder #(
    .SETTLE_CYCLES  (4),
    .STABLE_FRAMES  (2),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .value     (value),
    .valid     (valid),
    .update    (update),
    .digit_err (digit_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] disp;
    logic [3:0]  blank;
    logic        exp_upd;
    logic [15:0] exp_value;
    logic        exp_valid;
    logic [3:0]  exp_derr;
  } vec_t;

  vec_t        vecs [0:8];
  logic [15:0] exp_q [$];
  logic [15:0] obs_mem [0:255];
  int          obs_wr = 0;
  int          obs_rd = 0;
  int          n_vec  = 0;
  int          n_err  = 0;

  // Record every update pulse together with the value it carried.
  always @(negedge clk) begin
    if (rst_n && update) begin
      obs_mem[obs_wr[7:0]] <= value;
      obs_wr <= obs_wr + 1;
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show_digit(input int k, input logic [6:0] s, input int cycles);
    an  = ~(4'b0001 << k);
    seg = s;
    step(cycles);
  endtask

  task automatic scan_frame(input logic [15:0] disp, input logic [3:0] blank);
    for (int k = 0; k < 4; k++)
      show_digit(k, blank[k] ? 7'b1111111 : hex_to_seg(disp[k*4 +: 4]), 8);
  endtask

  // Compare observed update pulses against the scoreboard, then the static outputs.
  task automatic end_frame(input string tag, input logic [15:0] ev, input logic ed, input logic [3:0] ee);
    int n_obs;
    logic [15:0] e;
    n_obs = obs_wr - obs_rd;
    chk({tag, ".update_count"}, 32'(n_obs), 32'(exp_q.size()));
    while (obs_rd < obs_wr) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, ".update_value"}, {16'h0, obs_mem[obs_rd[7:0]]}, {16'h0, e});
      end
      obs_rd++;
    end
    exp_q.delete();
    chk({tag, ".value"}, {16'h0, value}, {16'h0, ev});
    chk({tag, ".valid"}, {31'h0, valid}, {31'h0, ed});
    chk({tag, ".digit_err"}, {28'h0, digit_err}, {28'h0, ee});
  endtask

  initial begin
    vecs[0] = '{16'h4321, 4'b0000, 1'b0, 16'h0000, 1'b0, 4'b0000};
    vecs[1] = '{16'h4321, 4'b0000, 1'b1, 16'h4321, 1'b1, 4'b0000};
    vecs[2] = '{16'hBEEF, 4'b0000, 1'b0, 16'h4321, 1'b1, 4'b0000};
    vecs[3] = '{16'hBEEF, 4'b0000, 1'b1, 16'hBEEF, 1'b1, 4'b0000};
    vecs[4] = '{16'hB7EF, 4'b0000, 1'b0, 16'hBEEF, 1'b1, 4'b0000};
    vecs[5] = '{16'hB7EF, 4'b0000, 1'b1, 16'hB7EF, 1'b1, 4'b0000};
    vecs[6] = '{16'hB7EF, 4'b0010, 1'b0, 16'hB7EF, 1'b1, 4'b0010};
    vecs[7] = '{16'hB7EF, 4'b0000, 1'b0, 16'hB7EF, 1'b1, 4'b0000};
    vecs[8] = '{16'hB7EF, 4'b0000, 1'b1, 16'hB7EF, 1'b1, 4'b0000};

    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    step(3);
    chk("reset.value", {16'h0, value}, 32'h0);
    chk("reset.valid", {31'h0, valid}, 32'h0);
    chk("reset.update", {31'h0, update}, 32'h0);
    chk("reset.digit_err", {28'h0, digit_err}, 32'h0);
    chk("reset.frame_err", {31'h0, frame_err}, 32'h0);
    rst_n = 1'b1;
    step(2);

    // Table-driven frames.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].exp_upd) exp_q.push_back(vecs[i].exp_value);
      scan_frame(vecs[i].disp, vecs[i].blank);
      end_frame($sformatf("frame%0d", i), vecs[i].exp_value, vecs[i].exp_valid, vecs[i].exp_derr);
    end

    // Timeout: idle bus; valid survives below the limit, drops past it, value kept.
    an  = 4'hF;
    seg = 7'h7F;
    step(40);
    chk("timeout.before_valid", {31'h0, valid}, 32'h1);
    step(40);
    chk("timeout.after_valid", {31'h0, valid}, 32'h0);
    chk("timeout.after_value", {16'h0, value}, 32'hB7EF);

    // Illegal anodes mid-scan: sticky frame_err, scanning recovers.
    show_digit(0, hex_to_seg(4'hF), 8);
    show_digit(1, hex_to_seg(4'hE), 8);
    chk("illegal.frame_err_before", {31'h0, frame_err}, 32'h0);
    an  = 4'b1100;
    seg = hex_to_seg(4'h7);
    step(3);
    chk("illegal.frame_err_set", {31'h0, frame_err}, 32'h1);
    show_digit(2, hex_to_seg(4'h7), 8);
    show_digit(3, hex_to_seg(4'hB), 8);
    end_frame("illegal.f1", 16'hB7EF, 1'b0, 4'b0000);
    exp_q.push_back(16'hB7EF);
    scan_frame(16'hB7EF, 4'b0000);
    end_frame("illegal.f2", 16'hB7EF, 1'b1, 4'b0000);
    chk("illegal.frame_err_sticky", {31'h0, frame_err}, 32'h1);

    // Reset in the middle of settling a digit of a partial frame.
    show_digit(0, hex_to_seg(4'h8), 8);
    show_digit(1, hex_to_seg(4'h7), 8);
    show_digit(2, hex_to_seg(4'h6), 2);
    rst_n = 1'b0;
    #2;
    chk("midreset.value", {16'h0, value}, 32'h0);
    chk("midreset.valid", {31'h0, valid}, 32'h0);
    chk("midreset.update", {31'h0, update}, 32'h0);
    chk("midreset.digit_err", {28'h0, digit_err}, 32'h0);
    chk("midreset.frame_err", {31'h0, frame_err}, 32'h0);
    step(2);
    obs_rd = obs_wr;
    rst_n = 1'b1;
    show_digit(2, hex_to_seg(4'h6), 8);
    show_digit(3, hex_to_seg(4'h5), 8);
    scan_frame(16'h5678, 4'b0000);
    end_frame("midreset.f1", 16'h0000, 1'b0, 4'b0000);
    exp_q.push_back(16'h5678);
    scan_frame(16'h5678, 4'b0000);
    end_frame("midreset.f2", 16'h5678, 1'b1, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
